// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC engine.
// Holds FSM encoding, mode constants, the 32-bit arctangent table and the inverse gain.
// The angle helper rounds each table entry to the binary-angle width in use.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // 1/K for the full CORDIC gain in Q2.30; callers rescale to their DATA_W.
    localparam int CORDIC_INV_GAIN_Q30 = 652032874;

    // atan(2^-i) in binary angle units where 2^32 is one full turn.
    function automatic logic [31:0] atan_entry(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd0:    v = 32'h2000_0000;
            4'd1:    v = 32'h12E4_051E;
            4'd2:    v = 32'h09FB_385B;
            4'd3:    v = 32'h0511_11D4;
            4'd4:    v = 32'h028B_0D43;
            4'd5:    v = 32'h0145_D7E1;
            4'd6:    v = 32'h00A2_F61E;
            4'd7:    v = 32'h0051_7C55;
            4'd8:    v = 32'h0028_BE53;
            4'd9:    v = 32'h0014_5F2F;
            4'd10:   v = 32'h000A_2F98;
            4'd11:   v = 32'h0005_17CC;
            4'd12:   v = 32'h0002_8BE6;
            4'd13:   v = 32'h0001_45F3;
            4'd14:   v = 32'h0000_A2FA;
            default: v = 32'h0000_517D;
        endcase
        return v;
    endfunction

    // Table entry rounded to its top aw bits, right-aligned. Entries are small
    // enough that adding the rounding half-LSB cannot overflow 32 bits.
    function automatic logic [31:0] atan_angle(input logic [3:0] idx, input int aw);
        logic [31:0] t;
        t = atan_entry(idx) + (32'd1 << (31 - aw));
        return t >> (32 - aw);
    endfunction

endpackage

// File: rtl/cordic_engine_stage.sv
// One CORDIC micro-rotation, purely combinational.
// Rotation steers on the sign of z, vectoring steers on the sign of y.
// Shifts are arithmetic so negative x/y keep their sign.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int W       = 18,
    parameter int ANGLE_W = 16
) (
    input  logic signed [W-1:0]       x,
    input  logic signed [W-1:0]       y,
    input  logic        [ANGLE_W-1:0] z,
    input  logic        [3:0]         i,
    input  logic                      mode,
    input  logic        [ANGLE_W-1:0] atan_i,
    output logic signed [W-1:0]       x_nxt,
    output logic signed [W-1:0]       y_nxt,
    output logic        [ANGLE_W-1:0] z_nxt
);

    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;
    logic                d_pos;

    // Apply one rotation by +/- atan(2^-i); z wraps modulo the angle width by design.
    always_comb begin
        xs    = x >>> i;
        ys    = y >>> i;
        d_pos = (mode == MODE_ROT) ? ~z[ANGLE_W-1] : y[W-1];
        if (d_pos) begin
            x_nxt = x - ys;
            y_nxt = y + xs;
            z_nxt = z - atan_i;
        end else begin
            x_nxt = x + ys;
            y_nxt = y - xs;
            z_nxt = z + atan_i;
        end
    end

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC core: rotation (sin/cos) or vectoring (magnitude/atan2), one micro-rotation per clock.
// Latency: result registered on the ITER-th edge after acceptance, o_Done pulses the following cycle.
// Accepts a request only in IDLE (o_Ready); requests while busy are dropped, not queued.
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ANGLE_W = 16,
    parameter int ITER    = 12,
    parameter int GUARD   = 2
) (
    input  logic                i_clock,
    input  logic                i_Reset,
    input  logic                i_Valid,
    input  logic                i_Mode,
    input  logic [DATA_W-1:0]   i_X,
    input  logic [DATA_W-1:0]   i_Y,
    input  logic [ANGLE_W-1:0]  i_Theta,
    output logic                o_Ready,
    output logic                o_Busy,
    output logic                o_Done,
    output logic [DATA_W-1:0]   o_X,
    output logic [DATA_W-1:0]   o_Y,
    output logic [ANGLE_W-1:0]  o_Z
);

    localparam int W = DATA_W + GUARD;
    localparam logic [ANGLE_W-1:0] QUARTER  = {2'b01, {(ANGLE_W-2){1'b0}}};
    localparam logic [3:0]         LAST_IT  = 4'(ITER - 1);
    localparam logic signed [W-1:0] SAT_MAX = {{(GUARD+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {{(GUARD+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t state, state_nxt;

    logic signed [W-1:0]       x_r, y_r, x_nx, y_nx;
    logic signed [W-1:0]       x_in, y_in, x_pre, y_pre;
    logic        [ANGLE_W-1:0] z_r, z_nx, z_pre, atan_i;
    logic        [3:0]         iter_cnt;
    logic                      mode_r;
    logic                      zero_vec;

    function automatic logic [DATA_W-1:0] sat(input logic signed [W-1:0] v);
        logic signed [W-1:0] c;
        if (v > SAT_MAX)      c = SAT_MAX;
        else if (v < SAT_MIN) c = SAT_MIN;
        else                  c = v;
        return DATA_W'(c);
    endfunction

    assign x_in   = {{GUARD{i_X[DATA_W-1]}}, i_X};
    assign y_in   = {{GUARD{i_Y[DATA_W-1]}}, i_Y};
    assign atan_i = ANGLE_W'(atan_angle(iter_cnt, ANGLE_W));

    // Quadrant pre-rotation so the iterations only have to cover +/-99.9 degrees.
    always_comb begin
        x_pre = x_in;
        y_pre = y_in;
        z_pre = i_Theta;
        if (i_Mode == MODE_ROT) begin
            case (i_Theta[ANGLE_W-1:ANGLE_W-2])
                2'b01: begin
                    x_pre = -y_in;
                    y_pre = x_in;
                    z_pre = i_Theta - QUARTER;
                end
                2'b10: begin
                    x_pre = y_in;
                    y_pre = -x_in;
                    z_pre = i_Theta + QUARTER;
                end
                default: ;
            endcase
        end else begin
            z_pre = '0;
            if (x_in[W-1]) begin
                if (!y_in[W-1]) begin
                    x_pre = y_in;
                    y_pre = -x_in;
                    z_pre = QUARTER;
                end else begin
                    x_pre = -y_in;
                    y_pre = x_in;
                    z_pre = -QUARTER;
                end
            end
        end
    end

    cordic_stage #(
        .W       (W),
        .ANGLE_W (ANGLE_W)
    ) u_stage (
        .x      (x_r),
        .y      (y_r),
        .z      (z_r),
        .i      (iter_cnt),
        .mode   (mode_r),
        .atan_i (atan_i),
        .x_nxt  (x_nx),
        .y_nxt  (y_nx),
        .z_nxt  (z_nx)
    );

    // FSM state register.
    always_ff @(posedge i_clock) begin
        if (i_Reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic: accept, iterate ITER times, pulse done for one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_Valid) state_nxt = CALC;
            CALC:    if (iter_cnt == LAST_IT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        o_Ready = (state == IDLE);
        o_Busy  = (state == CALC);
        o_Done  = (state == DONE);
    end

    // Datapath: load on acceptance, iterate in CALC, register saturated results on the last step.
    // A zero vector in vectoring mode has no defined angle; its z is forced to zero.
    always_ff @(posedge i_clock) begin
        if (i_Reset) begin
            x_r      <= '0;
            y_r      <= '0;
            z_r      <= '0;
            iter_cnt <= '0;
            mode_r   <= MODE_ROT;
            zero_vec <= 1'b0;
            o_X      <= '0;
            o_Y      <= '0;
            o_Z      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Valid) begin
                        x_r      <= x_pre;
                        y_r      <= y_pre;
                        z_r      <= z_pre;
                        iter_cnt <= '0;
                        mode_r   <= i_Mode;
                        zero_vec <= (i_Mode == MODE_VEC) && (i_X == '0) && (i_Y == '0);
                    end
                end
                CALC: begin
                    x_r      <= x_nx;
                    y_r      <= y_nx;
                    z_r      <= z_nx;
                    iter_cnt <= iter_cnt + 4'd1;
                    if (iter_cnt == LAST_IT) begin
                        o_X <= sat(x_nx);
                        o_Y <= sat(y_nx);
                        o_Z <= zero_vec ? '0 : z_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed bench for cordic_engine at DATA_W=16, ANGLE_W=16, ITER=12.
// Expected values are hand-derived (one=16384, gain ~1.6468).
module tb_cordic_engine;

    logic        i_clock = 1'b0;
    logic        i_Reset;
    logic        i_Valid;
    logic        i_Mode;
    logic [15:0] i_X;
    logic [15:0] i_Y;
    logic [15:0] i_Theta;
    logic        o_Ready;
    logic        o_Busy;
    logic        o_Done;
    logic [15:0] o_X;
    logic [15:0] o_Y;
    logic [15:0] o_Z;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clock = ~i_clock;

    cordic_engine #(
        .DATA_W  (16),
        .ANGLE_W (16),
        .ITER    (12),
        .GUARD   (2)
    ) dut (
        .i_clock (i_clock),
        .i_Reset (i_Reset),
        .i_Valid (i_Valid),
        .i_Mode  (i_Mode),
        .i_X     (i_X),
        .i_Y     (i_Y),
        .i_Theta (i_Theta),
        .o_Ready (o_Ready),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done),
        .o_X     (o_X),
        .o_Y     (o_Y),
        .o_Z     (o_Z)
    );

    // Compare with tolerance; modw>0 compares modulo 2^modw (for wrapping angles).
    task automatic check(input string tag, input int obs, input int exp,
                         input int tol = 0, input int modw = 0);
        int d;
        d = obs - exp;
        if (modw > 0) begin
            d = d & ((1 << modw) - 1);
            if (d >= (1 << (modw - 1))) d = d - (1 << modw);
        end
        n_tests++;
        if (d > tol || d < -tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic wait_ready();
        for (int k = 0; k < 50 && !o_Ready; k++) begin
            @(posedge i_clock); #1;
        end
    endtask

    // Present one request for one edge (E0); returns #1 after E0.
    task automatic start(input logic mode, input int x, input int y, input int theta);
        i_Mode  = mode;
        i_X     = 16'(x);
        i_Y     = 16'(y);
        i_Theta = 16'(theta);
        i_Valid = 1'b1;
        @(posedge i_clock); #1;
        i_Valid = 1'b0;
    endtask

    // Full operation; leaves time in the o_Done cycle and checks the latency.
    task automatic run_op(input string tag, input logic mode, input int x,
                          input int y, input int theta);
        int lat;
        wait_ready();
        check({tag, "_ready"}, int'(o_Ready), 1);
        start(mode, x, y, theta);
        lat = 0;
        for (int k = 0; k < 40 && !o_Done; k++) begin
            @(posedge i_clock); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 12);
    endtask

    typedef struct {
        int theta;
        int ex;
        int ey;
    } rot_vec_t;

    rot_vec_t rot_tab[4] = '{
        '{32'h2000,  11585,  11585},
        '{32'h6000, -11585,  11585},
        '{32'h8000, -16384,      0},
        '{32'hC000,      0, -16384}
    };

    initial begin
        int dones;
        i_Reset = 1'b1;
        i_Valid = 1'b0;
        i_Mode  = 1'b0;
        i_X     = '0;
        i_Y     = '0;
        i_Theta = '0;
        repeat (3) @(posedge i_clock);
        #1;
        i_Reset = 1'b0;

        // Reset state
        check("rst_ready", int'(o_Ready), 1);
        check("rst_busy",  int'(o_Busy),  0);
        check("rst_done",  int'(o_Done),  0);
        check("rst_x", sx(o_X), 0);
        check("rst_y", sx(o_Y), 0);
        check("rst_z", int'(o_Z), 0);

        // Rotation by 0: cos/sin of 0, plus done pulse width
        run_op("rot0", 1'b0, 9949, 0, 0);
        check("rot0_x", sx(o_X), 16384, 8);
        check("rot0_y", sx(o_Y), 0, 8);
        @(posedge i_clock); #1;
        check("rot0_done_width", int'(o_Done), 0);

        // Rotation across all quadrants
        foreach (rot_tab[n]) begin
            run_op($sformatf("rot%0d", n), 1'b0, 9949, 0, rot_tab[n].theta);
            check($sformatf("rot%0d_x", n), sx(o_X), rot_tab[n].ex, 8);
            check($sformatf("rot%0d_y", n), sx(o_Y), rot_tab[n].ey, 8);
        end

        // Vectoring
        run_op("vec45", 1'b1, 8192, 8192, 0);
        check("vec45_z", int'(o_Z), 32'h2000, 4, 16);
        check("vec45_x", sx(o_X), 19079, 16);
        check("vec45_y", sx(o_Y), 0, 8);

        run_op("vec180", 1'b1, -8192, 0, 0);
        check("vec180_z", int'(o_Z), 32'h8000, 4, 16);
        check("vec180_x", sx(o_X), 13491, 16);

        run_op("vecm90", 1'b1, 0, -8192, 0);
        check("vecm90_z", int'(o_Z), 32'hC000, 4, 16);

        run_op("vec0", 1'b1, 0, 0, 0);
        check("vec0_x", sx(o_X), 0);
        check("vec0_y", sx(o_Y), 0);
        check("vec0_z", int'(o_Z), 0);

        // Request while busy is dropped
        wait_ready();
        start(1'b0, 9949, 0, 32'h2000);
        repeat (3) begin
            @(posedge i_clock); #1;
        end
        check("ign_busy", int'(o_Busy), 1);
        start(1'b0, 5000, 3000, 32'h8000);
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            if (o_Done) dones++;
            @(posedge i_clock); #1;
        end
        check("ign_done_count", dones, 1);
        check("ign_x", sx(o_X), 11585, 8);
        check("ign_y", sx(o_Y), 11585, 8);

        // A request in IDLE is accepted again
        run_op("acc", 1'b0, 9949, 0, 32'hC000);
        check("acc_x", sx(o_X), 0, 8);
        check("acc_y", sx(o_Y), -16384, 8);

        // Reset in the middle of a computation
        wait_ready();
        start(1'b0, 9949, 0, 32'h2000);
        repeat (5) begin
            @(posedge i_clock); #1;
        end
        check("mid_busy", int'(o_Busy), 1);
        i_Reset = 1'b1;
        @(posedge i_clock); #1;
        i_Reset = 1'b0;
        check("mid_ready", int'(o_Ready), 1);
        check("mid_busy_after", int'(o_Busy), 0);
        check("mid_x", sx(o_X), 0);
        check("mid_y", sx(o_Y), 0);
        check("mid_z", int'(o_Z), 0);
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_Done) dones++;
            @(posedge i_clock); #1;
        end
        check("mid_no_done", dones, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
